pux_operand_loader: RTL and testbench
=====================================

# pux_operand_loader

Operand loader placed directly upstream of `pux_si`.
- Accepts one command: opcode, word length, and three base addresses.
- Sends the opcode on `axis_opcode_*`.
- Reads the A, B and M operands from a synchronous single-port operand RAM and streams them on `axis_abuff_*`, `axis_bbuff_*` and `axis_mbuff_*`.
- Holds `stream_request` high while a transfer is in progress.

## Interface

Parameters:
- `OPCW`, 8, opcode width
- `DATAW`, 16, operand word width
- `ADDRW`, 10, operand RAM address width
- `LENW`, 8, operand length field width (words per operand)

Ports:
- `aclk` in 1: the only clock.
- `aresetn` in 1: asynchronous, active-low reset.
- `cmd_opcode` in OPCW: opcode to forward.
- `cmd_len` in LENW: words per operand, range 0..2^LENW-1.
- `cmd_abase`, `cmd_bbase`, `cmd_mbase` in ADDRW each: operand base addresses.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake.
- `mem_rd` out 1, `mem_addr` out ADDRW: RAM read request.
- `mem_rdata` in DATAW: RAM data, valid in the cycle after `mem_rd`.
- `axis_opcode_data` out OPCW, `axis_opcode_valid` out 1, `axis_opcode_ready` in 1.
- `axis_abuff_data` out DATAW, `axis_abuff_valid` out 1, `axis_abuff_ready` in 1.
- `axis_bbuff_data`, `axis_bbuff_valid`, `axis_bbuff_ready`: same shape as A.
- `axis_mbuff_data`, `axis_mbuff_valid`, `axis_mbuff_ready`: same shape as A.
- `stream_request` out 1: high while a command is in progress.
- `busy` out 1: high when the FSM is not in IDLE.

## Operation

- FSM states: IDLE, RD_A, RD_B, RD_M, DRAIN.
- `cmd_ready` = (state==IDLE). `busy` = `stream_request` = (state!=IDLE).
- Command acceptance (`cmd_valid & cmd_ready`):
  - Latch len and the three bases; clear word counter `cnt`.
  - Push {tag=OPC, opcode zero-extended} into the output FIFO.
  - Next state is RD_A, or DRAIN if len==0.
- Output FIFO: 3 entries of {tag[1:0], data[DATAW-1:0]}.
  - Tags: 0=OPC, 1=A, 2=B, 3=M.
  - The head drives only the stream selected by its tag: that stream's valid = fifo non-empty & tag match; all other valids are 0.
  - Pop on valid & ready of the selected stream.
- Read issue:
  - `mem_rd` = (state in RD_A/RD_B/RD_M) & (fifo_count + inflight ≤ 2).
  - `mem_rd` and `mem_addr` are combinational from registers only; there is no path from any ready input.
- Addresses:
  - `mem_addr` = base_of_state + `cnt`, truncated to ADDRW bits, so it wraps modulo 2^ADDRW.
  - When `mem_rd`=0, `mem_addr` holds the last computed value.
- Data return: `inflight` is 1 bit, set by `mem_rd`. The following cycle, `mem_rdata` is pushed with the tag captured at issue.
- Counter and state advance:
  - `cnt` increments on each issue.
  - On the issue with `cnt`==len-1: `cnt` clears and the state advances RD_A→RD_B→RD_M→DRAIN.
- DRAIN → IDLE when the FIFO is empty and `inflight`==0.
- Push and pop in the same cycle are legal, and the count is unchanged. Overflow cannot occur under the issue rule.
- Reset mid-operation: FSM, FIFO, `cnt` and `inflight` clear immediately; pending data is discarded.

## Timing

Reset values:
- `cmd_ready`=1.
- `busy`, `stream_request`, `mem_rd`, and all `axis_*_valid` = 0.
- `mem_addr`=0 and all data outputs = 0.

Latency with all readies held high (command accepted at the end of cycle 0):
- Cycle 1: `axis_opcode_valid`=1, `mem_rd`=1 with `mem_addr`=abase.
- Cycle 3: A0 valid.
- Words then follow back-to-back at 1 word/cycle across A, B and M.
- The last M word is valid in cycle 3·len+2.
- `cmd_ready` returns to 1 in cycle 3·len+3.
- For len==0: opcode valid in cycle 1, IDLE in cycle 2 if opcode ready was high.

Handshakes:
- Valid, once asserted, stays high with data stable until ready.
- Ready may be low arbitrarily.
- At most 3 words are buffered plus 1 in flight.

## Structure

- Shared package `pux_pkg`:
  - tag constants TAG_OPC/TAG_A/TAG_B/TAG_M;
  - FSM state encoding;
  - default OPCW/DATAW. These are shared with `pux_si`.
- Sub-module `pux_sync_fifo` (parameterised width/depth, count output) implements the 3-entry output FIFO.
- The FSM, counter, address generation and tag demux live in `pux_operand_loader`.

## Test plan

- Reset: assert `aresetn`=0 with random inputs → `cmd_ready`=1, all valids 0, `mem_rd`=0, `stream_request`=0.
- Basic transfer:
  - Stimulus: opcode 0x35, len=2, abase=0x010, bbase=0x020, mbase=0x030; RAM[0x010..]={0x1111,0x2222}, [0x020..]={0x3333,0x4444}, [0x030..]={0x5555,0x6666}; all readies high.
  - Required: 0x35 in cycle 1, then A, B and M words in cycles 3..8; `cmd_ready` high in cycle 9.
- len=0, opcode 0xA0 → only the opcode is emitted, no `mem_rd` pulses, back to IDLE in cycle 2.
- Backpressure:
  - Stimulus: len=8; `axis_abuff_ready`=0 for cycles 2..15.
  - Required: `mem_rd` stops once 3 A words are buffered; all 8 A words are delivered in address order after ready rises; no loss or duplication.
- Wrap: abase=0x3FE, len=4 → `mem_addr` sequence 0x3FE, 0x3FF, 0x000, 0x001.
- Reset mid-stream: assert `aresetn` low after the second B word → all valids 0 immediately; after release, `cmd_ready`=1 and a new command streams correctly from A0.

Source files
------------

// File: rtl/pux_pkg.sv
// pux_pkg: tags, FSM state encoding and default widths shared by the pux operand path and pux_si.
package pux_pkg;
    localparam int OPCW_DEF  = 8;
    localparam int DATAW_DEF = 16;
    localparam logic [1:0] TAG_OPC = 2'd0;
    localparam logic [1:0] TAG_A   = 2'd1;
    localparam logic [1:0] TAG_B   = 2'd2;
    localparam logic [1:0] TAG_M   = 2'd3;
    typedef enum logic [2:0] {ST_IDLE, ST_RD_A, ST_RD_B, ST_RD_M, ST_DRAIN} state_t;
endpackage

// File: rtl/pux_sync_fifo.sv
// pux_sync_fifo: small circular FIFO with occupancy count.
// Ports: aclk/aresetn clock and async active-low reset; push/push_data write side;
// pop read side; head is the oldest entry; count is the current occupancy.
module pux_sync_fifo #(
    parameter int W = 18,
    parameter int DEPTH = 3,
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
    endfunction
    assign head = mem[rd_ptr];
    always_ff @(posedge aclk) begin
        if (push) mem[wr_ptr] <= push_data;
    end
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= inc(wr_ptr);
            if (pop) rd_ptr <= inc(rd_ptr);
            count <= (push && !pop) ? count + CW'(1) : (pop && !push) ? count - CW'(1) : count;
        end
    end
endmodule

// File: rtl/pux_operand_loader.sv
// pux_operand_loader: fetches A/B/M operands from a sync RAM and streams them with the opcode to pux_si.
// Ports: aclk/aresetn clock and async active-low reset; cmd_* command handshake;
// mem_rd/mem_addr/mem_rdata operand RAM read port; axis_{opcode,abuff,bbuff,mbuff}_* output streams;
// stream_request/busy high while a command is in progress.
module pux_operand_loader
    import pux_pkg::*;
#(
    parameter int OPCW  = OPCW_DEF,
    parameter int DATAW = DATAW_DEF,
    parameter int ADDRW = 10,
    parameter int LENW  = 8
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [OPCW-1:0]  cmd_opcode,
    input  logic [LENW-1:0]  cmd_len,
    input  logic [ADDRW-1:0] cmd_abase,
    input  logic [ADDRW-1:0] cmd_bbase,
    input  logic [ADDRW-1:0] cmd_mbase,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    output logic             mem_rd,
    output logic [ADDRW-1:0] mem_addr,
    input  logic [DATAW-1:0] mem_rdata,
    output logic [OPCW-1:0]  axis_opcode_data,
    output logic             axis_opcode_valid,
    input  logic             axis_opcode_ready,
    output logic [DATAW-1:0] axis_abuff_data,
    output logic             axis_abuff_valid,
    input  logic             axis_abuff_ready,
    output logic [DATAW-1:0] axis_bbuff_data,
    output logic             axis_bbuff_valid,
    input  logic             axis_bbuff_ready,
    output logic [DATAW-1:0] axis_mbuff_data,
    output logic             axis_mbuff_valid,
    input  logic             axis_mbuff_ready,
    output logic             stream_request,
    output logic             busy
);
    state_t           state_q, state_d;
    logic [LENW-1:0]  len_q, cnt_q;
    logic [ADDRW-1:0] abase_q, bbase_q, mbase_q, addr_q, base, addr_calc;
    logic             inflight_q;
    logic [1:0]       inflight_tag_q, cur_tag, head_tag, fifo_count;
    logic [DATAW+1:0] push_data, head;
    logic [DATAW-1:0] head_data;
    logic             accept, issue, last_word, push, pop, head_valid, drain_done;
    assign cmd_ready      = state_q == ST_IDLE;
    assign busy           = !cmd_ready;
    assign stream_request = busy;
    assign accept         = cmd_valid && cmd_ready;
    assign base    = state_q == ST_RD_A ? abase_q : state_q == ST_RD_B ? bbase_q : mbase_q;
    assign cur_tag = state_q == ST_RD_A ? TAG_A : state_q == ST_RD_B ? TAG_B : TAG_M;
    assign addr_calc = base + ADDRW'(cnt_q);
    // Issue only when the FIFO can absorb every word already requested plus this one.
    assign issue     = (state_q inside {ST_RD_A, ST_RD_B, ST_RD_M}) &&
                       ({1'b0, fifo_count} + {2'b0, inflight_q} <= 3'd2);
    assign mem_rd    = issue;
    assign mem_addr  = issue ? addr_calc : addr_q;
    assign last_word = cnt_q == len_q - LENW'(1);
    assign push      = accept || inflight_q;
    assign push_data = accept ? {TAG_OPC, DATAW'(cmd_opcode)} : {inflight_tag_q, mem_rdata};
    assign head_tag   = head[DATAW+1:DATAW];
    assign head_data  = head[DATAW-1:0];
    assign head_valid = fifo_count != 2'd0;
    assign axis_opcode_valid = head_valid && head_tag == TAG_OPC;
    assign axis_abuff_valid  = head_valid && head_tag == TAG_A;
    assign axis_bbuff_valid  = head_valid && head_tag == TAG_B;
    assign axis_mbuff_valid  = head_valid && head_tag == TAG_M;
    assign axis_opcode_data  = axis_opcode_valid ? head_data[OPCW-1:0] : '0;
    assign axis_abuff_data   = axis_abuff_valid ? head_data : '0;
    assign axis_bbuff_data   = axis_bbuff_valid ? head_data : '0;
    assign axis_mbuff_data   = axis_mbuff_valid ? head_data : '0;
    assign pop = (axis_opcode_valid && axis_opcode_ready) || (axis_abuff_valid && axis_abuff_ready) ||
                 (axis_bbuff_valid && axis_bbuff_ready) || (axis_mbuff_valid && axis_mbuff_ready);
    // Leave DRAIN as the last entry is handed off, so cmd_ready returns the cycle after it.
    assign drain_done = !inflight_q && fifo_count == {1'b0, pop};
    pux_sync_fifo #(.W(DATAW + 2), .DEPTH(3)) u_fifo (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .push     (push),
        .push_data(push_data),
        .pop      (pop),
        .head     (head),
        .count    (fifo_count)
    );
    always_comb begin
        state_d = state_q;
        if (accept) state_d = cmd_len == '0 ? ST_DRAIN : ST_RD_A;
        else if (issue && last_word)
            state_d = state_q == ST_RD_A ? ST_RD_B : state_q == ST_RD_B ? ST_RD_M : ST_DRAIN;
        else if (state_q == ST_DRAIN && drain_done) state_d = ST_IDLE;
    end
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q        <= ST_IDLE;
            len_q          <= '0;
            cnt_q          <= '0;
            abase_q        <= '0;
            bbase_q        <= '0;
            mbase_q        <= '0;
            addr_q         <= '0;
            inflight_q     <= 1'b0;
            inflight_tag_q <= TAG_OPC;
        end else begin
            state_q    <= state_d;
            inflight_q <= issue;
            if (accept) begin
                len_q   <= cmd_len;
                cnt_q   <= '0;
                abase_q <= cmd_abase;
                bbase_q <= cmd_bbase;
                mbase_q <= cmd_mbase;
            end
            if (issue) begin
                cnt_q          <= last_word ? '0 : cnt_q + LENW'(1);
                addr_q         <= addr_calc;
                inflight_tag_q <= cur_tag;
            end
        end
    end
endmodule

// File: tb/tb_pux_operand_loader.sv
// tb_pux_operand_loader: directed and randomized checks of pux_operand_loader against an in-order stream model.
module tb_pux_operand_loader;
    logic        aclk = 1'b0, aresetn = 1'b0;
    logic [7:0]  cmd_opcode = '0, cmd_len = '0;
    logic [9:0]  cmd_abase = '0, cmd_bbase = '0, cmd_mbase = '0;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic        mem_rd;
    logic [9:0]  mem_addr;
    logic [15:0] mem_rdata = '0;
    logic [7:0]  axis_opcode_data;
    logic        axis_opcode_valid, axis_opcode_ready = 1'b1;
    logic [15:0] axis_abuff_data, axis_bbuff_data, axis_mbuff_data;
    logic        axis_abuff_valid, axis_bbuff_valid, axis_mbuff_valid;
    logic        axis_abuff_ready = 1'b1, axis_bbuff_ready = 1'b1, axis_mbuff_ready = 1'b1;
    logic        stream_request, busy;
    logic [15:0] ram [1024];
    logic [17:0] exp_q [$];
    logic [9:0]  addr_exp [$];
    int          errors = 0, checks = 0, rd_pulses = 0, b_seen = 0;
    logic        rand_rdy = 1'b0;

    pux_operand_loader dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_opcode(cmd_opcode), .cmd_len(cmd_len),
        .cmd_abase(cmd_abase), .cmd_bbase(cmd_bbase), .cmd_mbase(cmd_mbase),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .axis_opcode_data(axis_opcode_data), .axis_opcode_valid(axis_opcode_valid), .axis_opcode_ready(axis_opcode_ready),
        .axis_abuff_data(axis_abuff_data), .axis_abuff_valid(axis_abuff_valid), .axis_abuff_ready(axis_abuff_ready),
        .axis_bbuff_data(axis_bbuff_data), .axis_bbuff_valid(axis_bbuff_valid), .axis_bbuff_ready(axis_bbuff_ready),
        .axis_mbuff_data(axis_mbuff_data), .axis_mbuff_valid(axis_mbuff_valid), .axis_mbuff_ready(axis_mbuff_ready),
        .stream_request(stream_request), .busy(busy)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) if (mem_rd) mem_rdata <= ram[mem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [17:0] cur_word();
        if (axis_opcode_valid) return {2'd0, 8'h00, axis_opcode_data};
        if (axis_abuff_valid) return {2'd1, axis_abuff_data};
        if (axis_bbuff_valid) return {2'd2, axis_bbuff_data};
        if (axis_mbuff_valid) return {2'd3, axis_mbuff_data};
        return 18'h3FFFF;
    endfunction

    // Reference: each accepted command expands into the exact word sequence and address sequence it must produce.
    always @(negedge aclk) begin
        int nval;
        logic [1:0] tag;
        logic rdy;
        if (!aresetn) begin
            exp_q.delete();
            addr_exp.delete();
        end else begin
            if (cmd_valid && cmd_ready) begin
                exp_q.push_back({2'd0, 8'h00, cmd_opcode});
                for (int s = 0; s < 3; s++) begin
                    for (int i = 0; i < int'(cmd_len); i++) begin
                        logic [9:0] a;
                        a = (s == 0 ? cmd_abase : s == 1 ? cmd_bbase : cmd_mbase) + 10'(i);
                        exp_q.push_back({2'(s + 1), ram[a]});
                        addr_exp.push_back(a);
                    end
                end
            end
            if (mem_rd) begin
                rd_pulses++;
                if (addr_exp.size() == 0) chk("unexpected_mem_rd", {22'b0, mem_addr}, 32'hFFFF_FFFF);
                else chk("mem_addr", {22'b0, mem_addr}, {22'b0, addr_exp.pop_front()});
            end
            nval = int'(axis_opcode_valid) + int'(axis_abuff_valid) + int'(axis_bbuff_valid) + int'(axis_mbuff_valid);
            if (nval > 1) chk("multi_valid", nval, 1);
            else if (nval == 1) begin
                tag = cur_word() >> 16;
                rdy = tag == 0 ? axis_opcode_ready : tag == 1 ? axis_abuff_ready : tag == 2 ? axis_bbuff_ready : axis_mbuff_ready;
                if (exp_q.size() == 0) chk("unexpected_valid", {14'b0, cur_word()}, 32'hFFFF_FFFF);
                else begin
                    chk("stream_word", {14'b0, cur_word()}, {14'b0, exp_q[0]});
                    if (rdy) begin
                        void'(exp_q.pop_front());
                        if (tag == 2) b_seen++;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge aclk);
            #1;
            if (rand_rdy) begin
                axis_opcode_ready = $urandom_range(0, 9) < 7;
                axis_abuff_ready  = $urandom_range(0, 9) < 7;
                axis_bbuff_ready  = $urandom_range(0, 9) < 7;
                axis_mbuff_ready  = $urandom_range(0, 9) < 7;
            end
        end
    end

    task automatic send(input logic [7:0] opc, input logic [7:0] len, input logic [9:0] ab, input logic [9:0] bb, input logic [9:0] mb);
        int n;
        @(posedge aclk);
        #1;
        n = 0;
        while (!cmd_ready && n < 500) begin
            @(posedge aclk);
            #1;
            n++;
        end
        if (!cmd_ready) chk("cmd_ready_timeout", 0, 1);
        cmd_opcode = opc; cmd_len = len; cmd_abase = ab; cmd_bbase = bb; cmd_mbase = mb;
        cmd_valid = 1'b1;
        @(posedge aclk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while (!(cmd_ready && exp_q.size() == 0) && n < 2000);
        if (n >= 2000) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        logic [17:0] basic_tbl [6];
        logic [9:0]  wrap_tbl [4];
        int r0, b0;
        basic_tbl = '{18'h11111, 18'h12222, 18'h23333, 18'h24444, 18'h35555, 18'h36666};
        wrap_tbl = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        for (int i = 0; i < 1024; i++) ram[i] = 16'($urandom);
        ram[10'h010] = 16'h1111; ram[10'h011] = 16'h2222;
        ram[10'h020] = 16'h3333; ram[10'h021] = 16'h4444;
        ram[10'h030] = 16'h5555; ram[10'h031] = 16'h6666;

        // Reset with random command inputs
        repeat (2) @(posedge aclk);
        #1;
        cmd_valid = 1'b1; cmd_opcode = 8'($urandom); cmd_len = 8'($urandom_range(1, 9));
        cmd_abase = 10'($urandom); axis_abuff_ready = 1'b0;
        @(posedge aclk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_valids", {axis_opcode_valid, axis_abuff_valid, axis_bbuff_valid, axis_mbuff_valid}, 0);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_stream_request", {stream_request, busy}, 0);
        chk("rst_outputs", {mem_addr, axis_opcode_data, axis_abuff_data}, 0);
        cmd_valid = 1'b0; axis_abuff_ready = 1'b1;
        aresetn = 1'b1;

        // Basic transfer
        send(8'h35, 8'd2, 10'h010, 10'h020, 10'h030);
        for (int c = 1; c <= 9; c++) begin
            @(negedge aclk);
            if (c == 1) begin
                chk("basic_opcode", {axis_opcode_valid, axis_opcode_data}, {1'b1, 8'h35});
                chk("basic_first_rd", {mem_rd, mem_addr}, {1'b1, 10'h010});
            end
            if (c >= 3 && c <= 8) chk("basic_word", {14'b0, cur_word()}, {14'b0, basic_tbl[c-3]});
            if (c == 8) chk("basic_busy_c8", cmd_ready, 0);
            if (c == 9) chk("basic_ready_c9", cmd_ready, 1);
        end

        // len == 0
        r0 = rd_pulses;
        send(8'hA0, 8'd0, 10'h100, 10'h200, 10'h300);
        for (int c = 1; c <= 3; c++) begin
            @(negedge aclk);
            if (c == 1) chk("len0_opcode", {axis_opcode_valid, axis_opcode_data}, {1'b1, 8'hA0});
            if (c == 2) chk("len0_idle_c2", cmd_ready, 1);
        end
        chk("len0_no_rd", rd_pulses - r0, 0);

        // Address wrap
        send(8'h5A, 8'd4, 10'h3FE, 10'h100, 10'h200);
        for (int c = 1; c <= 4; c++) begin
            @(negedge aclk);
            chk("wrap_addr", {mem_rd, mem_addr}, {1'b1, wrap_tbl[c-1]});
        end
        wait_idle();

        // Backpressure on A for cycles 2..15
        r0 = rd_pulses;
        send(8'h77, 8'd8, 10'h040, 10'h080, 10'h0C0);
        @(posedge aclk);
        #1;
        axis_abuff_ready = 1'b0;
        repeat (14) @(posedge aclk);
        #1;
        chk("bp_rd_stall", rd_pulses - r0, 3);
        axis_abuff_ready = 1'b1;
        wait_idle();

        // Reset after the second B word
        b0 = b_seen;
        send(8'h11, 8'd4, 10'($urandom), 10'($urandom), 10'($urandom));
        for (int n = 0; n < 200 && b_seen < b0 + 2; n++) @(negedge aclk);
        chk("mid_reset_reach_b", b_seen >= b0 + 2, 1);
        @(posedge aclk);
        #1;
        aresetn = 1'b0;
        #1;
        chk("mid_reset_valids", {axis_opcode_valid, axis_abuff_valid, axis_bbuff_valid, axis_mbuff_valid, mem_rd}, 0);
        chk("mid_reset_ready", {cmd_ready, stream_request}, 2'b10);
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        send(8'h22, 8'd3, 10'h150, 10'h160, 10'h170);
        @(negedge aclk);
        chk("post_reset_a0_addr", {mem_rd, mem_addr}, {1'b1, 10'h150});
        wait_idle();

        // Randomized commands with random backpressure
        rand_rdy = 1'b1;
        for (int k = 0; k < 40; k++) begin
            send(8'($urandom), 8'($urandom_range(0, 12)), 10'($urandom), 10'($urandom), 10'($urandom));
            repeat ($urandom_range(0, 3)) @(posedge aclk);
        end
        wait_idle();
        rand_rdy = 1'b0;
        @(posedge aclk);
        #2;
        axis_opcode_ready = 1'b1; axis_abuff_ready = 1'b1; axis_bbuff_ready = 1'b1; axis_mbuff_ready = 1'b1;
        repeat (3) @(negedge aclk);
        chk("final_queues_empty", exp_q.size() + addr_exp.size(), 0);
        chk("final_idle", {cmd_ready, busy}, 2'b10);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
